mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single on-chip SRAM port between three requesters: instruction fetch (port 0),
//  data load/store (port 1) and MPU table fill (port 2). Round-robin, one transaction at a time.
//  Sits between the cpu/mpu side and the memory, so the three requesters never drive
//  mem_wen/mem_addr concurrently.
// PARAMETERS
//  MEM_WORDS   1024  SRAM depth in 32-bit words; byte addr >= 4*MEM_WORDS is out of range
//  ADDR_WIDTH  22    byte-address width of every port
// PORTS
//  clk        in   1    single clock, all logic on posedge
//  resetn     in   1    asynchronous, active-low reset
//  req_valid  in   3    per-port request; bit i = port i; held high until ready
//  req_ready  out  3    one-hot, one-cycle completion pulse to the granted port
//  req_addr   in   66   port i byte addr at [22*i+21:22*i]
//  req_wdata  in   96   port i write data at [32*i+31:32*i]
//  req_wstrb  in   12   port i byte strobes at [4*i+3:4*i]; 4'b0000 = read
//  rsp_rdata  out  32   read data, valid only while req_ready != 0
//  rsp_err    out  1    out-of-range flag, valid only while req_ready != 0
//  grant_id   out  2    port currently served; 2'd3 when idle
//  mem_wen    out  4    SRAM byte write enables
//  mem_addr   out  22   SRAM byte address
//  mem_wdata  out  32   SRAM write data
//  mem_rdata  in   32   SRAM read data, valid 1 cycle after mem_addr is presented
// BEHAVIOUR
//  Reset (async, any state): FSM=IDLE, req_ready=0, rsp_rdata=0, rsp_err=0, grant_id=3,
//   mem_wen=0, mem_addr=0, mem_wdata=0, rr_last=2 (port 0 wins first). A transaction in flight is dropped.
//   No ready is issued for it.
//  All outputs are registered.
//  FSM IDLE -> ACCESS -> RESP -> IDLE (ACCESS skipped on error):
//   IDLE:   if any req_valid, pick a winner by round-robin. Search order is rr_last+1, +2, +3 (mod 3).
//           Latch its addr/wdata/wstrb, set grant_id and rr_last=winner.
//           In range: drive mem_addr/mem_wdata/mem_wen(=wstrb), go ACCESS.
//           Out of range (addr >= 4*MEM_WORDS): mem_wen stays 0, go RESP with err pending.
//   ACCESS: mem_wen forced back to 0 (write strobe lasts exactly one cycle). mem_addr held. Go RESP.
//   RESP:   req_ready[grant]=1 for this cycle only. rsp_rdata=mem_rdata for reads, 0 for writes/errors.
//           rsp_err=1 only for out-of-range. Next state IDLE, grant_id=3.
//  Latency: valid sampled in IDLE at edge N -> ready high in cycle N+2 (in range) / N+1 (error).
//  Throughput: one transaction per 3 cycles. A requester holding valid after its ready pulse
//   is treated as a new request at the next IDLE.
//  Requester inputs are ignored outside IDLE. Changes to a granted port's addr/wdata after
//   latching have no effect.
//  Simultaneous valid on all ports: served 0,1,2,0,... (no port waits more than 2 transactions).
//  Deasserting valid before ready is illegal for requesters. The arbiter completes the transaction anyway.
//  mem_addr is passed unaligned; the SRAM ignores bits [1:0].
// TESTING
//  1. Reset mid-ACCESS of a port-1 write -> next cycle all outputs at reset values, no req_ready pulse.
//  2. Port 0 read addr 0x10, mem_rdata=0xDEADBEEF -> req_ready=3'b001 2 cycles later,
//     rsp_rdata=0xDEADBEEF, rsp_err=0.
//  3. Port 1 write addr 0x20 wdata 0x12345678 wstrb 4'b0011 -> mem_wen=4'b0011 for exactly 1 cycle,
//     mem_addr=0x20, ready=3'b010.
//  4. All three valid continuously after reset -> ready order 001,010,100,001; one pulse every 3 cycles.
//  5. Port 2 read addr 4*MEM_WORDS=0x1000 -> mem_wen never set, ready=3'b100 next cycle,
//     rsp_err=1, rsp_rdata=0.
//  6. Port 0 valid, port 1 valid one cycle later while port 0 is in ACCESS -> port 0 completes,
//     then port 1 is granted in the following IDLE.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Requester/SRAM bundle shared by the three memory requesters and the arbiter.
// Latency: none, wires only.
// Backpressure: requesters hold req_valid until their one-cycle req_ready pulse.
//
// Signals:
//   req_valid/req_ready       per-port handshake, bit i = port i
//   req_addr/wdata/wstrb      packed per-port request fields (port i in slice i)
//   rsp_rdata/rsp_err         response, meaningful only while req_ready != 0
//   grant_id                  port being served, 3 when idle
//   mem_wen/addr/wdata/rdata  single SRAM port
interface mem_port_arbiter_if #(
  parameter int ADDR_WIDTH = 22
);
  logic [2:0]              req_valid;
  logic [2:0]              req_ready;
  logic [3*ADDR_WIDTH-1:0] req_addr;
  logic [95:0]             req_wdata;
  logic [11:0]             req_wstrb;
  logic [31:0]             rsp_rdata;
  logic                    rsp_err;
  logic [1:0]              grant_id;
  logic [3:0]              mem_wen;
  logic [ADDR_WIDTH-1:0]   mem_addr;
  logic [31:0]             mem_wdata;
  logic [31:0]             mem_rdata;

  // Arbiter view.
  modport slave (
    input  req_valid, req_addr, req_wdata, req_wstrb, mem_rdata,
    output req_ready, rsp_rdata, rsp_err, grant_id, mem_wen, mem_addr, mem_wdata
  );

  // Requester + SRAM view.
  modport master (
    output req_valid, req_addr, req_wdata, req_wstrb, mem_rdata,
    input  req_ready, rsp_rdata, rsp_err, grant_id, mem_wen, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one SRAM port between fetch (0), load/store (1), MPU fill (2).
// Latency: valid sampled in IDLE -> req_ready pulse 2 cycles later (1 cycle for out-of-range).
// Backpressure: one transaction at a time, 3 cycles each; requesters wait with valid held high.
//
// Ports:
//   clk, resetn  clock and asynchronous active-low reset
//   bus          mem_port_arbiter_if.slave: requester handshake, response, grant_id, SRAM port
module mem_port_arbiter #(
  parameter int MEM_WORDS  = 1024,
  parameter int ADDR_WIDTH = 22
) (
  input  logic               clk,
  input  logic               resetn,
  mem_port_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  // Byte addresses at or above this limit have no SRAM behind them.
  localparam logic [ADDR_WIDTH:0] ADDR_LIMIT = (ADDR_WIDTH + 1)'(4 * MEM_WORDS);

  state_t                state;
  logic [1:0]            rr_last;
  logic                  is_read;
  logic                  err_pend;

  logic [2:0]            ready_q;
  logic [31:0]           rdata_q;
  logic                  err_q;
  logic [1:0]            grant_q;
  logic [3:0]            wen_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           wdata_q;

  logic [1:0]            cand1, cand2, cand3;
  logic [1:0]            winner;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [31:0]           sel_wdata;
  logic [3:0]            sel_wstrb;
  logic                  in_range;

  function automatic logic [1:0] next_port(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Search starts just after the last winner, so the last winner is checked last.
  always_comb begin
    cand1 = next_port(rr_last);
    cand2 = next_port(cand1);
    cand3 = next_port(cand2);
    if (bus.req_valid[cand1])      winner = cand1;
    else if (bus.req_valid[cand2]) winner = cand2;
    else                           winner = cand3;

    sel_addr  = bus.req_addr[ADDR_WIDTH-1:0];
    sel_wdata = bus.req_wdata[31:0];
    sel_wstrb = bus.req_wstrb[3:0];
    case (winner)
      2'd1: begin
        sel_addr  = bus.req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH];
        sel_wdata = bus.req_wdata[63:32];
        sel_wstrb = bus.req_wstrb[7:4];
      end
      2'd2: begin
        sel_addr  = bus.req_addr[3*ADDR_WIDTH-1:2*ADDR_WIDTH];
        sel_wdata = bus.req_wdata[95:64];
        sel_wstrb = bus.req_wstrb[11:8];
      end
      default: ;
    endcase

    in_range = ({1'b0, sel_addr} < ADDR_LIMIT);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= IDLE;
      rr_last  <= 2'd2;
      is_read  <= 1'b0;
      err_pend <= 1'b0;
      ready_q  <= 3'b000;
      rdata_q  <= 32'h0;
      err_q    <= 1'b0;
      grant_q  <= 2'd3;
      wen_q    <= 4'h0;
      addr_q   <= '0;
      wdata_q  <= 32'h0;
    end else begin
      // Response fields are single-cycle; they only carry data alongside the ready pulse.
      ready_q <= 3'b000;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
      case (state)
        IDLE: begin
          if (|bus.req_valid) begin
            grant_q <= winner;
            rr_last <= winner;
            is_read <= (sel_wstrb == 4'h0);
            if (in_range) begin
              addr_q   <= sel_addr;
              wdata_q  <= sel_wdata;
              wen_q    <= sel_wstrb;
              err_pend <= 1'b0;
              state    <= ACCESS;
            end else begin
              // Never touch the SRAM for a bad address; answer straight away.
              err_pend <= 1'b1;
              state    <= RESP;
            end
          end
        end
        ACCESS: begin
          // Write strobe lasts exactly one cycle; the address stays put for the read.
          wen_q <= 4'h0;
          state <= RESP;
        end
        RESP: begin
          case (grant_q)
            2'd0:    ready_q <= 3'b001;
            2'd1:    ready_q <= 3'b010;
            2'd2:    ready_q <= 3'b100;
            default: ready_q <= 3'b000;
          endcase
          // SRAM data for the address launched in IDLE is valid during this cycle.
          rdata_q <= (is_read && !err_pend) ? bus.mem_rdata : 32'h0;
          err_q   <= err_pend;
          grant_q <= 2'd3;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready = ready_q;
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;
  assign bus.grant_id  = grant_q;
  assign bus.mem_wen   = wen_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a small registered-read SRAM model.
// Latency: checks sampled 1 time unit after each rising edge.
// Backpressure: requesters hold valid until their ready pulse, then drop it.
module tb_mem_port_arbiter;

  logic clk;
  logic resetn;
  int   n_tests;
  int   n_fail;

  mem_port_arbiter_if #(.ADDR_WIDTH(22)) bus ();

  mem_port_arbiter #(.MEM_WORDS(1024), .ADDR_WIDTH(22)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM model: byte-enabled write, read data one cycle after the address.
  logic [31:0] ram [1024];
  initial begin
    for (int i = 0; i < 1024; i++) ram[i] = 32'h0;
    ram[4] = 32'hDEADBEEF;   // byte address 0x10
    ram[12] = 32'hCAFEF00D;  // byte address 0x30
  end
  always @(posedge clk) begin
    for (int b = 0; b < 4; b++)
      if (bus.mem_wen[b]) ram[bus.mem_addr[11:2]][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
    bus.mem_rdata <= ram[bus.mem_addr[11:2]];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic set_port(input int p, input logic v, input logic [21:0] a,
                          input logic [31:0] d, input logic [3:0] s);
    bus.req_valid[p]        = v;
    bus.req_addr[22*p +: 22] = a;
    bus.req_wdata[32*p +: 32] = d;
    bus.req_wstrb[4*p +: 4]   = s;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready"}, {29'h0, bus.req_ready}, 32'h0);
    chk({tag, "_rdata"}, bus.rsp_rdata, 32'h0);
    chk({tag, "_err"},   {31'h0, bus.rsp_err}, 32'h0);
    chk({tag, "_grant"}, {30'h0, bus.grant_id}, 32'd3);
    chk({tag, "_wen"},   {28'h0, bus.mem_wen}, 32'h0);
    chk({tag, "_addr"},  {10'h0, bus.mem_addr}, 32'h0);
    chk({tag, "_wdata"}, bus.mem_wdata, 32'h0);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    bus.req_valid = 3'b000;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.req_wstrb = '0;
    resetn = 1'b0;
    tick();
    tick();
    chk_reset_outputs("rst");
    resetn = 1'b1;

    // Reset in the middle of a port-1 write: transaction dropped, no ready.
    set_port(1, 1'b1, 22'h40, 32'hAAAA5555, 4'hF);
    tick();
    chk("t1_wen", {28'h0, bus.mem_wen}, 32'hF);
    chk("t1_grant", {30'h0, bus.grant_id}, 32'd1);
    resetn = 1'b0;
    #1;
    chk_reset_outputs("t1_rst");
    set_port(1, 1'b0, 22'h0, 32'h0, 4'h0);
    tick();
    resetn = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t1_noready", {29'h0, bus.req_ready}, 32'h0);
    end

    // Port 0 read of 0x10.
    set_port(0, 1'b1, 22'h10, 32'h0, 4'h0);
    tick();
    chk("t2_grant", {30'h0, bus.grant_id}, 32'd0);
    chk("t2_addr", {10'h0, bus.mem_addr}, 32'h10);
    chk("t2_wen", {28'h0, bus.mem_wen}, 32'h0);
    tick();
    chk("t2_ready_early", {29'h0, bus.req_ready}, 32'h0);
    tick();
    chk("t2_ready", {29'h0, bus.req_ready}, 32'b001);
    chk("t2_rdata", bus.rsp_rdata, 32'hDEADBEEF);
    chk("t2_err", {31'h0, bus.rsp_err}, 32'h0);
    chk("t2_idle_grant", {30'h0, bus.grant_id}, 32'd3);
    set_port(0, 1'b0, 22'h0, 32'h0, 4'h0);
    tick();
    chk("t2_pulse_len", {29'h0, bus.req_ready}, 32'h0);
    chk("t2_rdata_clr", bus.rsp_rdata, 32'h0);

    // Port 1 partial write of 0x20.
    set_port(1, 1'b1, 22'h20, 32'h12345678, 4'b0011);
    tick();
    chk("t3_wen", {28'h0, bus.mem_wen}, 32'b0011);
    chk("t3_addr", {10'h0, bus.mem_addr}, 32'h20);
    chk("t3_wdata", bus.mem_wdata, 32'h12345678);
    chk("t3_grant", {30'h0, bus.grant_id}, 32'd1);
    tick();
    chk("t3_wen_off", {28'h0, bus.mem_wen}, 32'h0);
    chk("t3_addr_hold", {10'h0, bus.mem_addr}, 32'h20);
    tick();
    chk("t3_ready", {29'h0, bus.req_ready}, 32'b010);
    chk("t3_rdata", bus.rsp_rdata, 32'h0);
    chk("t3_err", {31'h0, bus.rsp_err}, 32'h0);
    set_port(1, 1'b0, 22'h0, 32'h0, 4'h0);
    tick();

    // Port 2 out-of-range read at 4*MEM_WORDS.
    set_port(2, 1'b1, 22'h1000, 32'h0, 4'h0);
    tick();
    chk("t5_grant", {30'h0, bus.grant_id}, 32'd2);
    chk("t5_wen", {28'h0, bus.mem_wen}, 32'h0);
    chk("t5_ready_early", {29'h0, bus.req_ready}, 32'h0);
    tick();
    chk("t5_ready", {29'h0, bus.req_ready}, 32'b100);
    chk("t5_err", {31'h0, bus.rsp_err}, 32'h1);
    chk("t5_rdata", bus.rsp_rdata, 32'h0);
    chk("t5_wen_after", {28'h0, bus.mem_wen}, 32'h0);
    set_port(2, 1'b0, 22'h0, 32'h0, 4'h0);
    tick();

    // Port 0 reads back 0x20; port 1 arrives while port 0 is in ACCESS.
    set_port(0, 1'b1, 22'h20, 32'h0, 4'h0);
    tick();
    chk("t6_grant0", {30'h0, bus.grant_id}, 32'd0);
    set_port(1, 1'b1, 22'h10, 32'h0, 4'h0);
    tick();
    chk("t6_grant_hold", {30'h0, bus.grant_id}, 32'd0);
    tick();
    chk("t6_ready0", {29'h0, bus.req_ready}, 32'b001);
    chk("t6_rdata0", bus.rsp_rdata, 32'h00005678);
    set_port(0, 1'b0, 22'h0, 32'h0, 4'h0);
    tick();
    chk("t6_grant1", {30'h0, bus.grant_id}, 32'd1);
    chk("t6_addr1", {10'h0, bus.mem_addr}, 32'h10);
    tick();
    tick();
    chk("t6_ready1", {29'h0, bus.req_ready}, 32'b010);
    chk("t6_rdata1", bus.rsp_rdata, 32'hDEADBEEF);
    set_port(1, 1'b0, 22'h0, 32'h0, 4'h0);
    tick();

    // Fresh reset, then all three ports request continuously.
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    set_port(0, 1'b1, 22'h10, 32'h0, 4'h0);
    set_port(1, 1'b1, 22'h20, 32'h0, 4'h0);
    set_port(2, 1'b1, 22'h30, 32'h0, 4'h0);
    for (int k = 0; k < 12; k++) begin
      logic [2:0] exp_rdy;
      tick();
      case (k)
        2:       exp_rdy = 3'b001;
        5:       exp_rdy = 3'b010;
        8:       exp_rdy = 3'b100;
        11:      exp_rdy = 3'b001;
        default: exp_rdy = 3'b000;
      endcase
      chk($sformatf("t4_ready_c%0d", k), {29'h0, bus.req_ready}, {29'h0, exp_rdy});
      if (k == 8) chk("t4_rdata2", bus.rsp_rdata, 32'hCAFEF00D);
    end
    bus.req_valid = 3'b000;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
